// File: rtl/sdram_init_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_init_monitor_pkg
// Purpose  : Shared command encodings, one-hot command indices, FSM states,
//            violation codes and the mode-word legality check.
// Revision : 1.0  initial release
// ============================================================================
package sdram_init_monitor_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_BST  = 4'b0110;
  localparam logic [3:0] CMD_NOP  = 4'b0111;

  localparam int CMD_TYPES = 8;

  typedef enum logic [2:0] {
    CT_NOP  = 3'd0,
    CT_PRE  = 3'd1,
    CT_AREF = 3'd2,
    CT_MRS  = 3'd3,
    CT_ACT  = 3'd4,
    CT_RD   = 3'd5,
    CT_WR   = 3'd6,
    CT_BST  = 3'd7
  } cmd_type_e;

  typedef enum logic [2:0] {
    ST_WAIT_PWR      = 3'd0,
    ST_WAIT_PRE_DONE = 3'd1,
    ST_AREF_PHASE    = 3'd2,
    ST_WAIT_MRD      = 3'd3,
    ST_DONE          = 3'd4,
    ST_ERROR         = 3'd5
  } state_e;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_PWR   = 3'd1;
  localparam logic [2:0] ERR_A10   = 3'd2;
  localparam logic [2:0] ERR_TRP   = 3'd3;
  localparam logic [2:0] ERR_TRFC  = 3'd4;
  localparam logic [2:0] ERR_ORDER = 3'd5;
  localparam logic [2:0] ERR_TMRD  = 3'd6;
  localparam logic [2:0] ERR_MODE  = 3'd7;

  // Only CAS latency 2/3 is supported; burst codes 4..6 are reserved.
  function automatic logic mode_word_bad(input logic [2:0] cl, input logic [2:0] bl);
    return !((cl == 3'd2) || (cl == 3'd3)) || ((bl >= 3'd4) && (bl <= 3'd6));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_init_monitor_cmd_decode.sv
`default_nettype none
// ============================================================================
// Module   : sdram_init_monitor_cmd_decode
// Purpose  : Combinational SDRAM command decode to a one-hot command type.
// Revision : 1.0  initial release
// ============================================================================
module sdram_init_monitor_cmd_decode
  import sdram_init_monitor_pkg::*;
(
  input  logic [3:0]           cmd,
  output logic [CMD_TYPES-1:0] cmd_oh
);

  always_comb begin
    cmd_oh = '0;
    case (cmd)
      CMD_NOP:  cmd_oh[CT_NOP]  = 1'b1;
      CMD_PRE:  cmd_oh[CT_PRE]  = 1'b1;
      CMD_AREF: cmd_oh[CT_AREF] = 1'b1;
      CMD_MRS:  cmd_oh[CT_MRS]  = 1'b1;
      CMD_ACT:  cmd_oh[CT_ACT]  = 1'b1;
      CMD_RD:   cmd_oh[CT_RD]   = 1'b1;
      CMD_WR:   cmd_oh[CT_WR]   = 1'b1;
      CMD_BST:  cmd_oh[CT_BST]  = 1'b1;
      default:  cmd_oh[CT_NOP]  = 1'b1;  // cs_n high: deselect behaves as NOP
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sdram_init_monitor.sv
`default_nettype none
// ============================================================================
// Module   : sdram_init_monitor
// Purpose  : Passive checker of the SDRAM power-up init sequence; flags the
//            first violation and latches the mode register.
//            Define SDRAM_INIT_MON_TIMING_EN to enable gap/power timing checks.
// Revision : 1.0  initial release
// ============================================================================
module sdram_init_monitor
  import sdram_init_monitor_pkg::*;
#(
  parameter int T_POWER  = 20000,
  parameter int T_RP     = 2,
  parameter int T_RFC    = 7,
  parameter int T_MRD    = 3,
  parameter int AREF_NUM = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [3:0]  cmd,
  input  logic [1:0]  ba,
  input  logic [12:0] addr,
  output logic        init_done,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [12:0] mode_reg,
  output logic [2:0]  cas_lat,
  output logic [2:0]  burst_len,
  output logic [3:0]  aref_cnt
);

  logic [CMD_TYPES-1:0] cmd_oh;
  logic                 non_nop;
  logic                 pwr_ok, rp_ok, rfc_ok, mrd_ok;

  sdram_init_monitor_cmd_decode u_decode (
    .cmd    (cmd),
    .cmd_oh (cmd_oh)
  );

  assign non_nop = ~cmd_oh[CT_NOP];

  logic unused_inputs;
  assign unused_inputs = ^{ba, cmd_oh[7:4]};

`ifdef SDRAM_INIT_MON_TIMING_EN
  localparam int GAP_MAX = ((T_POWER > T_RFC) ? T_POWER : T_RFC) + 1;
  localparam int GW      = $clog2(GAP_MAX + 1);
  localparam logic [GW-1:0] GAP_SAT   = GW'(GAP_MAX);
  localparam logic [GW-1:0] GAP_POWER = GW'(T_POWER);
  localparam logic [GW-1:0] GAP_RP    = GW'(T_RP);
  localparam logic [GW-1:0] GAP_RFC   = GW'(T_RFC);
  localparam logic [GW-1:0] GAP_MRD   = GW'(T_MRD);

  // Edges since the last command (or since reset, which doubles as the power-up timer)
  logic [GW-1:0] gap_q, gap_d;

  always_comb begin
    gap_d = gap_q;
    if (non_nop) begin
      gap_d = GW'(1);
    end else if (gap_q != GAP_SAT) begin
      gap_d = gap_q + GW'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) gap_q <= '0;
    else         gap_q <= gap_d;
  end

  assign pwr_ok = (gap_q >= GAP_POWER);
  assign rp_ok  = (gap_q >= GAP_RP);
  assign rfc_ok = (gap_q >= GAP_RFC);
  assign mrd_ok = (gap_q >= GAP_MRD);
`else
  localparam int unused_timing_params = T_POWER + T_RP + T_RFC + T_MRD;
  assign pwr_ok = 1'b1;
  assign rp_ok  = 1'b1;
  assign rfc_ok = 1'b1;
  assign mrd_ok = 1'b1;
`endif

  state_e      state_q, state_d;
  logic        err_q, err_d;
  logic [2:0]  err_code_q, err_code_d;
  logic        init_done_q, init_done_d;
  logic [12:0] mode_reg_q, mode_reg_d;
  logic [3:0]  aref_cnt_q, aref_cnt_d;
  logic        fail, aref_inc;
  logic [2:0]  fail_code;

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    init_done_d = init_done_q;
    mode_reg_d  = mode_reg_q;
    aref_cnt_d  = aref_cnt_q;
    fail        = 1'b0;
    fail_code   = ERR_NONE;
    aref_inc    = 1'b0;

    // Timing violations are tested first so they win over order errors
    case (state_q)
      ST_WAIT_PWR: begin
        if (non_nop) begin
          fail = 1'b1;
          if (!pwr_ok)                          fail_code = ERR_PWR;
          else if (cmd_oh[CT_PRE] && addr[10]) begin
            fail    = 1'b0;
            state_d = ST_WAIT_PRE_DONE;
          end
          else if (cmd_oh[CT_PRE])              fail_code = ERR_A10;
          else                                  fail_code = ERR_ORDER;
        end
      end
      ST_WAIT_PRE_DONE: begin
        if (non_nop) begin
          if (!rp_ok) begin
            fail      = 1'b1;
            fail_code = ERR_TRP;
          end else if (cmd_oh[CT_AREF]) begin
            aref_inc = 1'b1;
            state_d  = ST_AREF_PHASE;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_ORDER;
          end
        end
      end
      ST_AREF_PHASE: begin
        if (non_nop) begin
          if (!rfc_ok) begin
            fail      = 1'b1;
            fail_code = ERR_TRFC;
          end else if (cmd_oh[CT_AREF]) begin
            aref_inc = 1'b1;
          end else if (cmd_oh[CT_MRS] && (int'(aref_cnt_q) >= AREF_NUM)) begin
            mode_reg_d = addr;
            if (mode_word_bad(addr[6:4], addr[2:0])) begin
              fail      = 1'b1;
              fail_code = ERR_MODE;
            end else begin
              state_d = ST_WAIT_MRD;
            end
          end else begin
            fail      = 1'b1;
            fail_code = ERR_ORDER;
          end
        end
      end
      ST_WAIT_MRD: begin
        if (non_nop && !mrd_ok) begin
          fail      = 1'b1;
          fail_code = ERR_TMRD;
        end else if (mrd_ok) begin
          state_d     = ST_DONE;
          init_done_d = 1'b1;
        end
      end
      ST_DONE, ST_ERROR: ;
      default: ;
    endcase

    if (aref_inc && (aref_cnt_q != 4'hF)) begin
      aref_cnt_d = aref_cnt_q + 4'd1;
    end

    if (fail) begin
      state_d    = ST_ERROR;
      err_d      = 1'b1;
      err_code_d = fail_code;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_WAIT_PWR;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      init_done_q <= 1'b0;
      mode_reg_q  <= '0;
      aref_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      init_done_q <= init_done_d;
      mode_reg_q  <= mode_reg_d;
      aref_cnt_q  <= aref_cnt_d;
    end
  end

  assign init_done = init_done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign mode_reg  = mode_reg_q;
  assign cas_lat   = mode_reg_q[6:4];
  assign burst_len = mode_reg_q[2:0];
  assign aref_cnt  = aref_cnt_q;

endmodule
`default_nettype wire
